// File: rtl/gesture_pkg.sv
// Shared types for the gesture command arbiter: command encoding, FSM states,
// counter widths and small helper functions.
package gesture_pkg;

  localparam int unsigned CMD_W = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE   = 4'd0,
    CMD_ROT0   = 4'd1,
    CMD_ROT1   = 4'd2,
    CMD_ROT2   = 4'd3,
    CMD_ROT3   = 4'd4,
    CMD_KEY0   = 4'd5,
    CMD_KEY1   = 4'd6,
    CMD_KEY2   = 4'd7,
    CMD_KEY3   = 4'd8,
    CMD_DECIDE = 4'd9
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ISSUE,
    COOLDOWN
  } arb_state_t;

  // Per-frame candidate: a valid key always beats a valid rotation.
  function automatic cmd_t frame_candidate(input logic       key_valid,
                                           input logic [1:0] key,
                                           input logic       rot_valid,
                                           input logic [1:0] rot);
    cmd_t c;
    c = CMD_NONE;
    if (key_valid) begin
      unique case (key)
        2'd0: c = CMD_KEY0;
        2'd1: c = CMD_KEY1;
        2'd2: c = CMD_KEY2;
        2'd3: c = CMD_KEY3;
      endcase
    end else if (rot_valid) begin
      unique case (rot)
        2'd0: c = CMD_ROT0;
        2'd1: c = CMD_ROT1;
        2'd2: c = CMD_ROT2;
        2'd3: c = CMD_ROT3;
      endcase
    end
    return c;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for the raw decide button plus a one-cycle
// rising-edge pulse taken from the synchronised level.
module btn_sync_edge (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic rise_out
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Next values: shift the button through the synchroniser and edge history.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchroniser and edge-history registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_out = sync2_q & ~prev_q;

endmodule

// File: rtl/gesture_cmd_arbiter.sv
// Gesture command arbiter: turns per-frame rotate/key observations into
// debounced one-shot commands with a ready/valid handshake and a post-issue
// cooldown. Define GESTURE_ARB_DECIDE_BTN_EN to compile in the decide-button
// path (synchroniser, pending flag, DECIDE command).
module gesture_cmd_arbiter
  import gesture_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES   = 3,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             frame_tick_in,
  input  logic [1:0]       rotate_in,
  input  logic             rotate_valid_in,
  input  logic [1:0]       key_in,
  input  logic             key_valid_in,
  input  logic             btn_decide_in,
  input  logic             cmd_ready_in,
  output logic             cmd_valid_out,
  output logic [CMD_W-1:0] cmd_out,
  output logic             busy_out
);

  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0] COOL_N   = CNT_W'(COOLDOWN_FRAMES);

  arb_state_t       state_q, state_d;
  cmd_t             held_q, held_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [CNT_W-1:0] cooldown_cnt_q, cooldown_cnt_d;
  logic             cmd_valid_q, cmd_valid_d;
  cmd_t             cmd_q, cmd_d;
  logic [CNT_W-1:0] stable_inc;
  cmd_t             cand;
  logic             decide_pending_q;

  assign cand = frame_candidate(key_valid_in, key_in, rotate_valid_in, rotate_in);
  assign stable_inc = sat_inc(stable_cnt_q);

`ifdef GESTURE_ARB_DECIDE_BTN_EN
  logic btn_rise;
  logic decide_pending_d;

  btn_sync_edge u_btn_sync_edge (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .btn_in   (btn_decide_in),
    .rise_out (btn_rise)
  );

  // One-deep pending flag: cleared when IDLE/ARM services it; edges arriving
  // while it is set (including the servicing cycle) are dropped.
  always_comb begin
    decide_pending_d = decide_pending_q;
    if (decide_pending_q) begin
      if (state_q == IDLE || state_q == ARM) decide_pending_d = 1'b0;
    end else begin
      decide_pending_d = btn_rise;
    end
  end

  // Pending flag register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) decide_pending_q <= 1'b0;
    else        decide_pending_q <= decide_pending_d;
  end
`else
  logic unused_btn;
  assign unused_btn       = btn_decide_in;
  assign decide_pending_q = 1'b0;
`endif

  // Next-state logic; outputs are derived from the next state so they are
  // registered alongside it and always agree with it.
  always_comb begin
    state_d        = state_q;
    held_d         = held_q;
    stable_cnt_d   = stable_cnt_q;
    cooldown_cnt_d = cooldown_cnt_q;

    case (state_q)
      IDLE, ARM: begin
        if (decide_pending_q) begin
          held_d       = CMD_DECIDE;
          stable_cnt_d = '0;
          state_d      = ISSUE;
        end else if (frame_tick_in) begin
          if (cand == CMD_NONE) begin
            stable_cnt_d = '0;
            state_d      = IDLE;
          end else if (state_q == ARM && cand == held_q) begin
            stable_cnt_d = stable_inc;
            if (stable_inc >= STABLE_N) state_d = ISSUE;
          end else begin
            held_d       = cand;
            stable_cnt_d = CNT_W'(1);
            state_d      = (STABLE_N <= CNT_W'(1)) ? ISSUE : ARM;
          end
        end
      end

      ISSUE: begin
        if (cmd_valid_q && cmd_ready_in) begin
          stable_cnt_d = '0;
          if (COOL_N == '0) begin
            state_d = IDLE;
          end else begin
            cooldown_cnt_d = COOL_N;
            state_d        = COOLDOWN;
          end
        end
      end

      COOLDOWN: begin
        if (frame_tick_in) begin
          if (cooldown_cnt_q <= CNT_W'(1)) begin
            cooldown_cnt_d = '0;
            state_d        = IDLE;
          end else begin
            cooldown_cnt_d = cooldown_cnt_q - CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    cmd_valid_d = (state_d == ISSUE);
    cmd_d       = (state_d == ISSUE) ? held_d : CMD_NONE;
  end

  // FSM state, counters and registered command outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      held_q         <= CMD_NONE;
      stable_cnt_q   <= '0;
      cooldown_cnt_q <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_q          <= CMD_NONE;
    end else begin
      state_q        <= state_d;
      held_q         <= held_d;
      stable_cnt_q   <= stable_cnt_d;
      cooldown_cnt_q <= cooldown_cnt_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_q          <= cmd_d;
    end
  end

  assign cmd_valid_out = cmd_valid_q;
  assign cmd_out       = cmd_q;
  assign busy_out      = (state_q != IDLE);

endmodule

// File: doc/gesture_cmd_arbiter.md
GESTURE_CMD_ARBITER -- requirements
Module: gesture_cmd_arbiter

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 3: consecutive frame samples a candidate must hold before issue; legal range 1..15.
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 8: frame ticks of lockout after each issued command; legal range 0..15.
REQ-003 SHALL have port clk_in  input  1: 65 MHz pixel clock; one clock only.
REQ-004 SHALL have port rst_in  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port frame_tick_in  input  1: one-cycle pulse at hcount==0 && vcount==0.
REQ-006 SHALL have port rotate_in  input  2: rotation code from center-of-mass stage.
REQ-007 SHALL have port rotate_valid_in  input  1: rotate_in is meaningful this frame.
REQ-008 SHALL have port key_in  input  2: key code from key-input stage.
REQ-009 SHALL have port key_valid_in  input  1: key_in is meaningful this frame.
REQ-010 SHALL have port btn_decide_in  input  1: raw, unsynchronised decide button.
REQ-011 SHALL have port cmd_ready_in  input  1: game-state consumer accepts cmd this cycle.
REQ-012 SHALL have port cmd_valid_out  output  1: cmd_out holds a command.
REQ-013 SHALL have port cmd_out  output  4: 0 NONE, 1..4 ROT(rotate_in+1), 5..8 KEY(key_in+5), 9 DECIDE.
REQ-014 SHALL have port busy_out  output  1: high whenever state != IDLE.

Function
REQ-015 SHALL use FSM states IDLE, ARM, ISSUE, COOLDOWN.
REQ-016 SHALL form the candidate only on frame_tick_in: KEY if key_valid_in, else ROT if rotate_valid_in, else NONE (key beats rotate).
REQ-017 IDLE: a tick with candidate != NONE SHALL latch held=candidate and stable_cnt=1, then go to ARM, or go straight to ISSUE when STABLE_FRAMES==1.
REQ-018 ARM, per tick: same candidate -> stable_cnt+1, going to ISSUE when it reaches STABLE_FRAMES; different non-NONE -> held=new, stable_cnt=1; NONE -> IDLE.
REQ-019 ISSUE: cmd_valid_out=1 and cmd_out=held SHALL stay stable until cmd_valid_out && cmd_ready_in; frame ticks SHALL be ignored.
REQ-020 On handshake SHALL load cooldown_cnt=COOLDOWN_FRAMES and go to COOLDOWN, or to IDLE when COOLDOWN_FRAMES==0.
REQ-021 COOLDOWN: cooldown_cnt SHALL decrement per tick; the tick that reaches 0 SHALL return the FSM to IDLE, and that tick's candidate SHALL NOT be evaluated.
REQ-022 Rising edge of the synchronised button SHALL set a one-deep decide_pending flag; edges while it is set SHALL be dropped.
REQ-023 In IDLE or ARM with decide_pending set, the next cycle SHALL enter ISSUE with held=DECIDE and clear pending, aborting any ARM progress and bypassing the stability count.
REQ-024 In ISSUE or COOLDOWN, decide_pending SHALL persist and SHALL be serviced on the first IDLE cycle.
REQ-025 cmd_valid_out and cmd_out SHALL be registered; latency from the qualifying tick to cmd_valid_out is 1 cycle.
REQ-026 Button-edge to cmd_valid_out latency SHALL be 4 cycles from IDLE (2 sync, 1 edge, 1 issue).
REQ-027 cmd_out SHALL read 0 whenever cmd_valid_out is low.
REQ-028 Counters SHALL be 4 bits and saturate; no wrap-around.

Reset
REQ-029 rst_in SHALL asynchronously force state=IDLE, cmd_valid_out=0, cmd_out=0, busy_out=0, all counters=0, decide_pending=0 and synchroniser flops=0.
REQ-030 Reset during ISSUE SHALL drop the command without a handshake; release SHALL resume in IDLE on the next edge.

Configuration
REQ-031 With macro GESTURE_ARB_DECIDE_BTN_EN defined, the button path (REQ-022..024, REQ-026) SHALL be compiled in.
REQ-032 Without GESTURE_ARB_DECIDE_BTN_EN, btn_decide_in SHALL be unused, no synchroniser SHALL exist, and code 9 SHALL never be issued.

Structure
REQ-033 Package gesture_pkg SHALL hold the cmd_t encoding, the arb_state_t enum, CMD_W=4 and CNT_W=4.
REQ-034 Sub-module btn_sync_edge SHALL provide the 2-FF synchroniser plus rising-edge pulse.

Verification
REQ-035 Bench SHALL drive key_valid=1, key=2 for 3 ticks with ready=1 -> single cmd_out=7 pulse 1 cycle after the 3rd tick; busy_out remains high for 8 further ticks.
REQ-036 Bench SHALL drive rotate=1 for 2 ticks then rotate=3 for 3 ticks -> only cmd_out=4 is issued, none for rotate=1.
REQ-037 Bench SHALL drive key and rotate both valid for 3 ticks -> cmd_out is the KEY code.
REQ-038 Bench SHALL hold ready=0 for 20 cycles in ISSUE -> cmd_valid_out stays 1 with cmd_out constant; ready=1 -> handshake, then COOLDOWN.
REQ-039 Bench SHALL press the button mid-ARM -> cmd_out=9 after 4 cycles; a second press during COOLDOWN -> cmd_out=9 again on return to IDLE; a third press while pending -> dropped.
REQ-040 Bench SHALL assert rst_in mid-ISSUE -> cmd_valid_out=0 immediately, without waiting for a clock edge.
